// File: rtl/cvxif_compressed_req_queue.sv
// Request queue in front of the compressed-instruction decoder. The head entry is
// presented to the decoder, and the decoder's answer comes back as a registered response.
module cvxif_compressed_req_queue #(
  parameter int Depth   = 4,
  parameter int HartIdW = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               req_valid_i,
  input  logic [15:0]        req_instr_i,
  input  logic [HartIdW-1:0] req_hartid_i,
  output logic               req_ready_o,
  output logic               dec_valid_o,
  output logic [15:0]        dec_instr_o,
  output logic [HartIdW-1:0] dec_hartid_o,
  input  logic               dec_ready_i,
  input  logic               dec_accept_i,
  input  logic [31:0]        dec_instr_i,
  output logic               resp_valid_o,
  output logic               resp_accept_o,
  output logic [31:0]        resp_instr_o,
  output logic [HartIdW-1:0] resp_hartid_o,
  output logic [$clog2(Depth):0] occupancy_o
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] FULL = CntW'(Depth);

  typedef struct packed {
    logic [15:0]        instr;
    logic [HartIdW-1:0] hartid;
  } entry_t;

  entry_t          r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_push, w_pop;

  assign req_ready_o  = (r_count != FULL);
  assign dec_valid_o  = (r_count != '0);
  assign dec_instr_o  = r_mem[r_rd_ptr].instr;
  assign dec_hartid_o = r_mem[r_rd_ptr].hartid;
  assign occupancy_o  = r_count;
  assign w_push       = req_valid_i & req_ready_o;
  assign w_pop        = dec_valid_o & dec_ready_i;

  // Storage is not reset. A write in a flush cycle is harmless because the pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= '{instr: req_instr_i, hartid: req_hartid_i};
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_o  <= 1'b0;
      resp_accept_o <= 1'b0;
      resp_instr_o  <= '0;
      resp_hartid_o <= '0;
    end else if (flush_i) begin
      resp_valid_o  <= 1'b0;
    end else begin
      resp_valid_o <= w_pop;
      if (w_pop) begin
        resp_accept_o <= dec_accept_i;
        resp_hartid_o <= dec_hartid_o;
        resp_instr_o  <= dec_accept_i ? dec_instr_i : {16'h0, dec_instr_o};
      end
    end
  end
endmodule
